// File: rtl/apb_master.sv
// APB initiator: turns single-beat core commands into SETUP/ACCESS transfers
// toward GPIO/UART, with address decode and a bounded pready wait.
module apb_master #(
    parameter int TIMEOUT = 16,
    parameter int SEL_LSB = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] pAdd,
    output logic [31:0] pwData,
    output logic        pwr,
    output logic [1:0]  psel,
    output logic        pen,
    input  logic [31:0] prdata,
    input  logic        pready
);

    // Handshake: a command is taken on any edge where cmd_valid && cmd_ready.
    // cmd_ready is high only in IDLE; rsp_valid is a single-cycle pulse in RESP.

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      sel_q;
    logic [CW-1:0]   wait_cnt;
    logic [1:0]      dec_sel;
    logic            dec_ok;
    logic            timeout_hit;

    always_comb begin
        dec_sel = cmd_addr[SEL_LSB+1:SEL_LSB];
        dec_ok  = (dec_sel == 2'b01) || (dec_sel == 2'b10);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        psel        = 2'b00;
        pen         = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = dec_ok ? SETUP : RESP;
                end
            end
            SETUP: begin
                psel      = sel_q;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel = sel_q;
                pen  = 1'b1;
                if (pready) begin
                    state_nxt = RESP;
                end else if (wait_cnt == LAST_WAIT) begin
                    // pready has been low for TIMEOUT ACCESS cycles: abort.
                    timeout_hit = 1'b1;
                    state_nxt   = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= 2'b00;
            wait_cnt  <= '0;
            pAdd      <= 32'd0;
            pwData    <= 32'd0;
            pwr       <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (dec_ok) begin
                            sel_q  <= dec_sel;
                            pAdd   <= cmd_addr;
                            pwData <= cmd_wdata;
                            pwr    <= cmd_write;
                        end else begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end
                    end
                end
                SETUP: begin
                    wait_cnt <= '0;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_rdata <= pwr ? 32'd0 : prdata;
                        rsp_err   <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Bus-side initiator for the peripheral APB: turns single-beat commands from the core into APB SETUP/ACCESS transfers toward the GPIO and UART completers.
- Decodes the target from the command address and drives the 2-bit psel.
- Returns read data and an error flag, and bounds every transfer with a pready timeout so a hung completer cannot stall the core.

Parameters:
- TIMEOUT, 16, maximum ACCESS-phase cycles spent waiting for pready before aborting with error (must be >= 1).
- SEL_LSB, 12, bit position of the 2-bit target-select field in cmd_addr.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command (IDLE only).
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  32  transfer address; bits [SEL_LSB+1:SEL_LSB] select target.
- cmd_wdata  input  32  write data.
- rsp_valid  output  1  one-cycle pulse: command completed.
- rsp_rdata  output  32  read data, valid with rsp_valid on reads (0 on writes and errors).
- rsp_err  output  1  valid with rsp_valid: decode error or timeout.
- pAdd  output  32  APB address.
- pwData  output  32  APB write data.
- pwr  output  1  APB write strobe (1 = write).
- psel  output  2  APB select: 2'b01 GPIO, 2'b10 UART, 2'b00 idle.
- pen  output  1  APB enable.
- prdata  input  32  APB read data from selected completer.
- pready  input  1  APB ready from selected completer.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE.
  - cmd_ready=1 after reset.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - pAdd=0, pwData=0, pwr=0, psel=2'b00, pen=0.
  - Timeout counter=0.
  - Reset mid-transfer aborts the transfer immediately; no response is issued.
- Command accept: a handshake occurs when cmd_valid && cmd_ready at a clock edge. The block latches cmd_write, cmd_addr and cmd_wdata at that edge.
- Decode of sel = cmd_addr[SEL_LSB+1:SEL_LSB]:
  - 2'b01 or 2'b10 are valid targets.
  - 2'b00 and 2'b11 cause a decode error: go to RESP with rsp_err=1. No APB activity occurs (psel stays 00).
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE: cmd_ready=1, psel=00, pen=0. On handshake go to SETUP (valid target) or RESP (decode error).
  - SETUP (exactly 1 cycle): cmd_ready=0. psel=decoded target, pen=0, and pAdd/pwData/pwr driven from the latched command. Counter cleared. Always goes to ACCESS.
  - ACCESS: psel held, pen=1, pAdd/pwData/pwr held stable.
    - If pready=1 at the edge: capture prdata into rsp_rdata on reads (0 on writes), rsp_err=0, go to RESP.
    - Else increment the counter. When the counter reaches TIMEOUT without pready: rsp_err=1, rsp_rdata=0, go to RESP.
  - RESP (exactly 1 cycle): rsp_valid=1, psel=00, pen=0, cmd_ready=0. Next state is IDLE.
- rsp_valid is 0 in every state except RESP. rsp_rdata and rsp_err hold their values until the next RESP.
- pAdd, pwData and pwr retain their last values in IDLE and RESP. Only psel and pen return to 0.
- Latency with a valid target and zero wait states:
  - Handshake at edge 0.
  - SETUP in cycle 1, ACCESS in cycle 2 (pready sampled at the end of that cycle).
  - RESP in cycle 3, next handshake possible at edge 4.
  - Each extra wait cycle of pready adds 1 cycle.
- Timeout boundary: a transfer with pready first high in ACCESS cycle k (k = 1..TIMEOUT) completes normally. pready arriving later is ignored.
- A cmd_valid held high during a transfer is not accepted until IDLE. cmd_* values may change freely while cmd_ready=0.
- pready and prdata are ignored outside ACCESS.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release -> all outputs at reset values, cmd_ready=1, psel=00, pen=0.
- UART write, pready tied 1: cmd_write=1, addr=0x0000_2004, wdata=0x0000_0041 -> cycle 1 psel=10 pen=0, cycle 2 pen=1 pAdd=0x2004 pwData=0x41 pwr=1; cycle 3 rsp_valid=1 rsp_err=0 rsp_rdata=0; cmd_ready back at cycle 4.
- GPIO read with 3 wait states: addr=0x0000_1000, pready low for 3 ACCESS cycles then high with prdata=0xA5A5_0F0F -> psel=01, pen=1 for 4 cycles, rsp_valid one cycle later with rsp_rdata=0xA5A5_0F0F, rsp_err=0.
- Timeout with TIMEOUT=16 and pready stuck 0 -> pen high for exactly 16 cycles, then psel=00, rsp_valid=1, rsp_err=1, rsp_rdata=0. A following command completes normally.
- Decode error: addr=0x0000_3000 (sel=11), then 0x0000_0000 -> no psel/pen activity, rsp_valid=1 with rsp_err=1 in the cycle after each handshake.
- Reset mid-ACCESS plus back-to-back: assert rst during ACCESS -> no rsp_valid, psel=00 next cycle. Then issue two commands with cmd_valid held high -> second accepted exactly 4 cycles after the first (zero-wait completer).
